// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath/memories.
// Latency: none (wires only).
// Backpressure: imem_ready/dmem_ready stretch fetch and data access; no other flow control.
//
// master: the controller (drives enables, selects, requests, status, counters).
// slave : the datapath/memory side (drives run, opcode, branch condition, readies).
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    // datapath / memory -> controller
    logic             run;
    logic [5:0]       ir_op;
    logic             cond;
    logic             imem_ready;
    logic             dmem_ready;

    // controller -> datapath / memory
    logic             imem_req;
    logic             dmem_rd;
    logic             dmem_wr;
    logic             ir_we;
    logic             npc_we;
    logic             ab_we;
    logic             alu_we;
    logic             lmd_we;
    logic             pc_we;
    logic             pc_sel;
    logic             rf_we;
    logic             wb_sel;
    logic             dst_sel;
    logic [5:0]       ex_op;
    logic             retire;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        input  run, ir_op, cond, imem_ready, dmem_ready,
        output imem_req, dmem_rd, dmem_wr, ir_we, npc_we, ab_we, alu_we, lmd_we,
               pc_we, pc_sel, rf_we, wb_sel, dst_sel, ex_op, retire, halted,
               state, retired_cnt, cycle_cnt
    );

    modport slave (
        output run, ir_op, cond, imem_ready, dmem_ready,
        input  imem_req, dmem_rd, dmem_wr, ir_we, npc_we, ab_we, alu_we, lmd_we,
               pc_we, pc_sel, rf_we, wb_sel, dst_sel, ex_op, retire, halted,
               state, retired_cnt, cycle_cnt
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB one instruction at a time.
// Latency: R/ADDI/LW 5 cycles, SW/BEQZ/J/NOP 4, HALT 2, +1 per memory wait cycle.
// Backpressure: IF holds on imem_ready, MEM holds on dmem_ready (LW/SW only).
//
// Ports: clk, rst (synchronous, active high) and the bundle bus (master side):
//   inputs  run, ir_op, cond, imem_ready, dmem_ready
//   outputs memory requests, latch enables, PC/writeback/destination selects,
//           ex_op, retire pulse, halted, debug state, retire and cycle counters.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF     = 3'd1,
        S_ID     = 3'd2,
        S_EX     = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [5:0]       op_q;
    logic             cond_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] cycle_q;

    // Decode of the opcode captured in ID; everything after ID works from op_q
    // so the IR may change freely once decoded.
    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_mem;
    logic has_wb;
    logic take_alu_pc;
    logic mem_done;

    assign is_rtype    = (op_q == OP_RTYPE);
    assign is_lw       = (op_q == OP_LW);
    assign is_sw       = (op_q == OP_SW);
    assign is_mem      = is_lw | is_sw;
    assign has_wb      = is_rtype | (op_q == OP_ADDI) | is_lw;
    assign take_alu_pc = (op_q == OP_J) | ((op_q == OP_BEQZ) & cond_q);
    // Non-memory ops finish MEM immediately; dmem_ready is ignored for them.
    assign mem_done    = is_mem ? bus.dmem_ready : 1'b1;

    logic imem_req, dmem_rd, dmem_wr, ir_we, npc_we, ab_we, alu_we, lmd_we;
    logic pc_we, pc_sel, rf_we, wb_sel, dst_sel, retire, halted;

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_rd  = 1'b0;
        dmem_wr  = 1'b0;
        ir_we    = 1'b0;
        npc_we   = 1'b0;
        ab_we    = 1'b0;
        alu_we   = 1'b0;
        lmd_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        dst_sel  = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_IF;
            end
            S_IF: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    npc_we  = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                ab_we = 1'b1;
                // HALT is decoded straight from the IR: it retires here and
                // never reaches EX.
                if (bus.ir_op == OP_HALT) begin
                    retire  = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_we  = 1'b1;
                state_d = S_MEM;
            end
            S_MEM: begin
                // Requests are held for the whole access, including the
                // cycle in which ready arrives.
                dmem_rd = is_lw;
                dmem_wr = is_sw;
                if (mem_done) begin
                    lmd_we = is_lw;
                    pc_we  = 1'b1;
                    pc_sel = take_alu_pc;
                    if (has_wb) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = bus.run ? S_IF : S_IDLE;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = is_lw;
                dst_sel = is_rtype;
                retire  = 1'b1;
                state_d = bus.run ? S_IF : S_IDLE;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 6'h00;
            cond_q    <= 1'b0;
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) op_q   <= bus.ir_op;
            if (state_q == S_EX) cond_q <= bus.cond;
            if (retire) retired_q <= retired_q + CNT_ONE;
            // Active cycles are those spent inside an instruction (IF..WB).
            if ((state_q != S_IDLE) && (state_q != S_HALTED)) cycle_q <= cycle_q + CNT_ONE;
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.dmem_rd     = dmem_rd;
    assign bus.dmem_wr     = dmem_wr;
    assign bus.ir_we       = ir_we;
    assign bus.npc_we      = npc_we;
    assign bus.ab_we       = ab_we;
    assign bus.alu_we      = alu_we;
    assign bus.lmd_we      = lmd_we;
    assign bus.pc_we       = pc_we;
    assign bus.pc_sel      = pc_sel;
    assign bus.rf_we       = rf_we;
    assign bus.wb_sel      = wb_sel;
    assign bus.dst_sel     = dst_sel;
    assign bus.retire      = retire;
    assign bus.halted      = halted;
    assign bus.ex_op       = op_q;
    assign bus.state       = state_q;
    assign bus.retired_cnt = retired_q;
    assign bus.cycle_cnt   = cycle_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: builds an expected per-cycle trace from
// instruction-level descriptions, replays it with random don't-care inputs,
// and compares every cycle plus a few hand-computed counter values.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 32;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef struct packed {
        logic [2:0] state;
        logic imem_req, dmem_rd, dmem_wr, ir_we, npc_we, ab_we, alu_we, lmd_we;
        logic pc_we, pc_sel, rf_we, wb_sel, dst_sel, retire, halted;
        logic [5:0] ex_op;
    } out_t;

    typedef struct {
        logic       rst;
        logic       run;
        logic [5:0] ir_op;
        logic       cond;
        logic       imem_ready;
        logic       dmem_ready;
        out_t       exp;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    cyc_t       q[$];
    logic [5:0] last_op;
    int         mret, mcyc;
    int         checks = 0;
    int         errors = 0;
    int         cyc_no = 0;

    function automatic out_t cur_out();
        out_t o;
        o.state = bus.state;     o.imem_req = bus.imem_req; o.dmem_rd = bus.dmem_rd;
        o.dmem_wr = bus.dmem_wr; o.ir_we = bus.ir_we;       o.npc_we = bus.npc_we;
        o.ab_we = bus.ab_we;     o.alu_we = bus.alu_we;     o.lmd_we = bus.lmd_we;
        o.pc_we = bus.pc_we;     o.pc_sel = bus.pc_sel;     o.rf_we = bus.rf_we;
        o.wb_sel = bus.wb_sel;   o.dst_sel = bus.dst_sel;   o.retire = bus.retire;
        o.halted = bus.halted;   o.ex_op = bus.ex_op;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_no, act, exp);
        end
    endtask

    // A cycle whose inputs are all random (don't-cares) and whose outputs are all idle.
    function automatic cyc_t new_cyc(input logic [2:0] st);
        cyc_t c;
        c.rst        = 1'b0;
        c.run        = 1'($urandom_range(0, 1));
        c.ir_op      = 6'($urandom_range(0, 63));
        c.cond       = 1'($urandom_range(0, 1));
        c.imem_ready = 1'($urandom_range(0, 1));
        c.dmem_ready = 1'($urandom_range(0, 1));
        c.exp        = '0;
        c.exp.state  = st;
        c.exp.ex_op  = last_op;
        return c;
    endfunction

    task automatic gen_idle(input int n, input logic go);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = new_cyc(3'd0); c.run = 1'b0; q.push_back(c);
        end
        if (go) begin
            c = new_cyc(3'd0); c.run = 1'b1; q.push_back(c);
        end
    endtask

    task automatic gen_halted(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = new_cyc(3'd6); c.exp.halted = 1'b1; q.push_back(c);
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input int iw, input int dw,
                             input logic cnd, input logic run_next);
        cyc_t c;
        logic mem, wbk;
        mem = (op == OP_LW) || (op == OP_SW);
        wbk = (op == OP_R) || (op == OP_ADDI) || (op == OP_LW);
        for (int i = 0; i < iw; i++) begin
            c = new_cyc(3'd1); c.imem_ready = 1'b0; c.exp.imem_req = 1'b1; q.push_back(c);
        end
        c = new_cyc(3'd1); c.imem_ready = 1'b1;
        c.exp.imem_req = 1'b1; c.exp.ir_we = 1'b1; c.exp.npc_we = 1'b1; q.push_back(c);
        c = new_cyc(3'd2); c.ir_op = op; c.exp.ab_we = 1'b1;
        if (op == OP_HALT) c.exp.retire = 1'b1;
        q.push_back(c);
        last_op = op;
        if (op == OP_HALT) return;
        c = new_cyc(3'd3); c.cond = cnd; c.exp.alu_we = 1'b1; q.push_back(c);
        if (mem) begin
            for (int i = 0; i < dw; i++) begin
                c = new_cyc(3'd4); c.dmem_ready = 1'b0;
                c.exp.dmem_rd = (op == OP_LW); c.exp.dmem_wr = (op == OP_SW); q.push_back(c);
            end
        end
        c = new_cyc(3'd4);
        if (mem) c.dmem_ready = 1'b1;
        c.exp.dmem_rd = (op == OP_LW);
        c.exp.dmem_wr = (op == OP_SW);
        c.exp.lmd_we  = (op == OP_LW);
        c.exp.pc_we   = 1'b1;
        c.exp.pc_sel  = (op == OP_J) || ((op == OP_BEQZ) && cnd);
        if (!wbk) begin
            c.exp.retire = 1'b1; c.run = run_next;
        end
        q.push_back(c);
        if (wbk) begin
            c = new_cyc(3'd5);
            c.exp.rf_we = 1'b1; c.exp.wb_sel = (op == OP_LW); c.exp.dst_sel = (op == OP_R);
            c.exp.retire = 1'b1; c.run = run_next;
            q.push_back(c);
        end
    endtask

    // Fetch stalls for n cycles and reset is asserted in the last of them.
    task automatic gen_reset_in_if(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = new_cyc(3'd1); c.imem_ready = 1'b0; c.exp.imem_req = 1'b1;
            c.rst = (i == n - 1);
            q.push_back(c);
        end
        last_op = 6'h00;
    endtask

    // The single compare process: replays the trace one cycle at a time.
    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            rst            = c.rst;
            bus.run        = c.run;
            bus.ir_op      = c.ir_op;
            bus.cond       = c.cond;
            bus.imem_ready = c.imem_ready;
            bus.dmem_ready = c.dmem_ready;
            #1;
            cyc_no++;
            chk("outputs", 64'(cur_out()), 64'(c.exp));
            chk("retired_cnt", 64'(bus.retired_cnt), 64'(mret));
            chk("cycle_cnt", 64'(bus.cycle_cnt), 64'(mcyc));
            if (c.rst) begin
                mret = 0; mcyc = 0;
            end else begin
                if (c.exp.retire) mret++;
                if (c.exp.state >= 3'd1 && c.exp.state <= 3'd5) mcyc++;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        mret = 0; mcyc = 0; last_op = 6'h00;
    endtask

    initial begin
        logic [5:0] op;
        logic       rn;
        rst = 1'b1;
        bus.run = 1'b0; bus.ir_op = 6'h00; bus.cond = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        last_op = 6'h00; mret = 0; mcyc = 0;
        do_reset();

        // Reset state.
        chk("reset_outputs", 64'(cur_out()), 64'h0);
        chk("reset_retired", 64'(bus.retired_cnt), 64'd0);
        chk("reset_cycles", 64'(bus.cycle_cnt), 64'd0);

        // Single zero-wait R-type, then stop.
        gen_idle(0, 1'b1);
        gen_instr(OP_R, 0, 0, 1'b0, 1'b0);
        gen_idle(1, 1'b0);
        run_q();
        chk("rtype_retired", 64'(bus.retired_cnt), 64'd1);
        chk("rtype_cycles", 64'(bus.cycle_cnt), 64'd5);

        // LW with 3 wait states, both BEQZ outcomes, unknown opcode, SW with run dropped.
        gen_idle(0, 1'b1);
        gen_instr(OP_LW, 0, 3, 1'b0, 1'b1);
        gen_instr(OP_BEQZ, 0, 0, 1'b1, 1'b1);
        gen_instr(OP_BEQZ, 0, 0, 1'b0, 1'b1);
        gen_instr(6'h3E, 0, 0, 1'b1, 1'b1);
        gen_instr(OP_SW, 0, 0, 1'b0, 1'b0);
        gen_idle(2, 1'b0);
        run_q();
        chk("mix_retired", 64'(bus.retired_cnt), 64'd6);
        chk("mix_cycles", 64'(bus.cycle_cnt), 64'd29);
        chk("mix_state", 64'(bus.state), 64'd0);

        // Reset while fetch is stalled.
        gen_idle(0, 1'b1);
        gen_reset_in_if(3);
        gen_idle(1, 1'b0);
        run_q();
        chk("rst_if_outputs", 64'(cur_out()), 64'h0);
        chk("rst_if_retired", 64'(bus.retired_cnt), 64'd0);
        chk("rst_if_cycles", 64'(bus.cycle_cnt), 64'd0);

        // Randomized instruction stream with random wait states and pauses.
        gen_idle(0, 1'b1);
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_ADDI;
                2: op = OP_LW;
                3: op = OP_SW;
                4: op = OP_BEQZ;
                5: op = OP_J;
                default: op = 6'($urandom_range(0, 62));
            endcase
            rn = (i != 149) && ($urandom_range(0, 4) != 0);
            gen_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), rn);
            if (!rn && i != 149) gen_idle($urandom_range(0, 2), 1'b1);
        end
        gen_idle(1, 1'b0);
        run_q();
        chk("rand_retired_total", 64'(bus.retired_cnt), 64'd150);

        // ADDI then HALT; halted state ignores everything until reset.
        do_reset();
        gen_idle(0, 1'b1);
        gen_instr(OP_ADDI, 1, 0, 1'b0, 1'b1);
        gen_instr(OP_HALT, 0, 0, 1'b0, 1'b1);
        gen_halted(20);
        run_q();
        chk("halt_flag", 64'(bus.halted), 64'd1);
        chk("halt_state", 64'(bus.state), 64'd6);
        chk("halt_retired", 64'(bus.retired_cnt), 64'd2);
        chk("halt_cycles", 64'(bus.cycle_cnt), 64'd8);
        chk("halt_ex_op", 64'(bus.ex_op), 64'h3F);
        do_reset();
        chk("post_halt_outputs", 64'(cur_out()), 64'h0);
        chk("post_halt_retired", 64'(bus.retired_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
